// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC angle feeder: widths, FSM states,
// delay-line tag layout and the quadrant-folding helper.
package cordic_pkg;

   localparam int ANGLE_W         = 32;
   localparam int DATA_W          = 16;
   // A sweep never issues more angles than the CORDIC sample width can index.
   localparam int COUNT_W         = DATA_W;
   localparam int LATENCY_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } feeder_state_e;

   typedef struct packed {
      logic valid;
      logic fold;
   } tag_t;

   typedef struct packed {
      logic [ANGLE_W-1:0] angle;
      logic               fold;
   } folded_t;

   // Quadrants 1 and 2 are rotated by 180 degrees into [-90, +90); the caller
   // negates SIN/COS for those beats.
   function automatic folded_t fold_phase(input logic [ANGLE_W-1:0] phase);
      folded_t r;
      r.fold  = phase[ANGLE_W-1] ^ phase[ANGLE_W-2];
      r.angle = {phase[ANGLE_W-1] ^ r.fold, phase[ANGLE_W-2:0]};
      return r;
   endfunction

endpackage

// File: rtl/cordic_angle_feeder_if.sv
// Sweep command and angle stream between a controller and the feeder.
interface cordic_angle_feeder_if;
   import cordic_pkg::*;

   logic               start;
   logic [ANGLE_W-1:0] start_phase;
   logic [ANGLE_W-1:0] step;
   logic [COUNT_W-1:0] count;
   logic               out_ready;
   logic [ANGLE_W-1:0] angle_out;
   logic               angle_valid;
   logic               fold_out;
   logic               valid_dly;
   logic               fold_dly;
   logic               busy;
   logic               done;

   modport master (
      output start, start_phase, step, count, out_ready,
      input  angle_out, angle_valid, fold_out, valid_dly, fold_dly, busy, done
   );

   modport slave (
      input  start, start_phase, step, count, out_ready,
      output angle_out, angle_valid, fold_out, valid_dly, fold_dly, busy, done
   );

endinterface

// File: rtl/cordic_tag_delay.sv
// Free-running tag shift register that keeps per-beat side information aligned
// with a fixed-latency pipeline; also reports whether any stage holds a flag.
module cordic_tag_delay #(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = 2,
   parameter int FLAG_BIT = TAG_W - 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [TAG_W-1:0] tag_i,
   output logic [TAG_W-1:0] tag_o,
   output logic             flag_any_o
);

   logic [TAG_W-1:0] stage_q [DEPTH];

   // NOTE: every stage is reset so an abandoned sweep leaves no stale marker
   // that would later surface on the delayed outputs or hold off completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

   always_comb begin
      flag_any_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         flag_any_o = flag_any_o | stage_q[i][FLAG_BIT];
      end
   end

endmodule

// File: rtl/cordic_angle_feeder.sv
// Issues a phase sweep to a pipelined CORDIC as folded angles, and delays the
// valid/fold tags so they line up with the CORDIC results.
module cordic_angle_feeder
   import cordic_pkg::*;
#(
   parameter int LATENCY = LATENCY_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   cordic_angle_feeder_if.slave  bus
);

   feeder_state_e      state_q, state_d;
   logic [ANGLE_W-1:0] phase_q, phase_d;
   logic [ANGLE_W-1:0] step_q, step_d;
   logic [COUNT_W-1:0] remaining_q, remaining_d;
   folded_t            folded;
   tag_t               tag_in, tag_out;
   logic               tag_pending;
   logic               accept;

   assign folded = fold_phase(phase_q);
   assign accept = (state_q == ST_RUN) && bus.out_ready;

   always_comb begin
      // NOTE: every next-state value gets its hold default first, so no path
      // through the case leaves one unassigned and no latch is inferred.
      state_d     = state_q;
      phase_d     = phase_q;
      step_d      = step_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.count != '0) begin
                  state_d     = ST_RUN;
                  phase_d     = bus.start_phase;
                  step_d      = bus.step;
                  remaining_d = bus.count;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               phase_d     = phase_q + step_q;
               remaining_d = remaining_q - COUNT_W'(1);
               if (remaining_q == COUNT_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Completion waits until the last accepted beat has left the
            // delay line, i.e. its CORDIC result has been presented.
            if (!tag_pending) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         phase_q     <= '0;
         step_q      <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         step_q      <= step_d;
         remaining_q <= remaining_d;
      end
   end

   assign tag_in = '{valid: accept, fold: accept & folded.fold};

   cordic_tag_delay #(
      .DEPTH    (LATENCY),
      .TAG_W    ($bits(tag_t)),
      .FLAG_BIT ($bits(tag_t) - 1)
   ) u_tag_delay (
      .clk        (clk),
      .reset_n    (reset_n),
      .tag_i      (tag_in),
      .tag_o      (tag_out),
      .flag_any_o (tag_pending)
   );

   assign bus.angle_out   = folded.angle;
   assign bus.fold_out    = folded.fold;
   assign bus.angle_valid = (state_q == ST_RUN);
   assign bus.valid_dly   = tag_out.valid;
   assign bus.fold_dly    = tag_out.fold;
   assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign bus.done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_cordic_angle_feeder.sv
// Scoreboard bench for cordic_angle_feeder: stimulus queues expected beats, a
// negedge monitor checks angles, delayed tags and completion pulses.
module tb_cordic_angle_feeder;
   import cordic_pkg::*;

   localparam int          LAT   = LATENCY_DEFAULT;
   localparam logic [31:0] STEP1 = 32'h00B6_0B61; // ~1 degree

   typedef struct {
      logic [31:0] angle;
      logic        fold;
   } beat_t;

   typedef struct {
      int   cyc;
      logic fold;
   } dly_t;

   logic clk;
   logic reset_n;

   int cyc           = 0;
   int checks        = 0;
   int errors        = 0;
   int acc_count     = 0;
   int done_count    = 0;
   int vdly_count    = 0;
   int last_acc_cyc  = 0;
   int last_done_cyc = 0;

   beat_t exp_q[$];
   dly_t  exp_dly_q[$];
   int    vdly_cyc_q[$];

   cordic_angle_feeder_if bus ();

   cordic_angle_feeder #(.LATENCY(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_beat(input logic [31:0] angle, input logic fold);
      exp_q.push_back('{angle: angle, fold: fold});
   endtask

   // Reference fold written as an angle-range test rather than bit logic.
   function automatic beat_t model_fold(input logic [31:0] ph);
      beat_t b;
      if (ph >= 32'h4000_0000 && ph < 32'hC000_0000) begin
         b.angle = ph - 32'h8000_0000;
         b.fold  = 1'b1;
      end else begin
         b.angle = ph;
         b.fold  = 1'b0;
      end
      return b;
   endfunction

   // Monitor: all sampling on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_dly_q.delete();
      end else begin
         if (exp_dly_q.size() != 0 && exp_dly_q[0].cyc == cyc) begin
            check("valid_dly", bus.valid_dly, 1);
            check("fold_dly", bus.fold_dly, exp_dly_q[0].fold);
            void'(exp_dly_q.pop_front());
         end else if (bus.valid_dly) begin
            check("valid_dly_unexpected", bus.valid_dly, 0);
         end
         if (bus.valid_dly) begin
            vdly_count++;
            vdly_cyc_q.push_back(cyc);
         end
         if (bus.done) begin
            done_count++;
            last_done_cyc = cyc;
         end
         if (bus.angle_valid) begin
            if (exp_q.size() == 0) begin
               check("angle_valid_unexpected", bus.angle_valid, 0);
            end else begin
               check("angle_out", bus.angle_out, exp_q[0].angle);
               check("fold_out", bus.fold_out, exp_q[0].fold);
               if (bus.out_ready) begin
                  exp_dly_q.push_back('{cyc: cyc + LAT, fold: exp_q[0].fold});
                  void'(exp_q.pop_front());
                  acc_count++;
                  last_acc_cyc = cyc;
               end
            end
         end
      end
   end

   // Returns one cycle after the start edge, with command inputs scrambled.
   task automatic start_sweep(input logic [31:0] ph, input logic [31:0] st, input logic [15:0] n);
      @(posedge clk);
      #1;
      bus.start       = 1'b1;
      bus.start_phase = ph;
      bus.step        = st;
      bus.count       = n;
      @(posedge clk);
      #1;
      bus.start       = 1'b0;
      bus.start_phase = 32'hDEAD_BEEF;
      bus.step        = 32'h0BAD_F00D;
      bus.count       = 16'h0007;
   endtask

   task automatic end_sweep(input string name, input int d0, input int n_vdly);
      int n = 0;
      while (done_count == d0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check({name, "_done_count"}, done_count - d0, 1);
      check({name, "_vdly_count"}, vdly_cyc_q.size(), n_vdly);
      check({name, "_beats_left"}, exp_q.size(), 0);
      check({name, "_idle_busy"}, bus.busy, 0);
   endtask

   initial begin
      int d0;
      int a0;
      int v0;
      bus.start       = 1'b0;
      bus.start_phase = '0;
      bus.step        = '0;
      bus.count       = '0;
      bus.out_ready   = 1'b1;
      reset_n         = 1'b1;

      // Asynchronous reset, checked before any clock edge.
      #3 reset_n = 1'b0;
      #1;
      check("rst_angle_out", bus.angle_out, 0);
      check("rst_angle_valid", bus.angle_valid, 0);
      check("rst_fold_out", bus.fold_out, 0);
      check("rst_valid_dly", bus.valid_dly, 0);
      check("rst_fold_dly", bus.fold_dly, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // Quadrant sweep.
      vdly_cyc_q.delete();
      d0 = done_count;
      push_beat(32'h0000_0000, 1'b0);
      push_beat(32'hC000_0000, 1'b1);
      push_beat(32'h0000_0000, 1'b1);
      push_beat(32'hC000_0000, 1'b0);
      start_sweep(32'h0000_0000, 32'h4000_0000, 16'd4);
      check("quad_busy", bus.busy, 1);
      end_sweep("quad", d0, 4);
      // Accept sampled at cycle k lands on edge k+1; done follows LATENCY+1 edges later.
      check("quad_done_latency", last_done_cyc - last_acc_cyc, LAT + 2);

      // Backpressure: second beat stalled for three cycles.
      vdly_cyc_q.delete();
      d0 = done_count;
      push_beat(32'h1000_0000, 1'b0);
      push_beat(32'hC000_0000, 1'b1);
      push_beat(32'hF000_0000, 1'b1);
      start_sweep(32'h1000_0000, 32'h3000_0000, 16'd3);
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.out_ready = 1'b1;
      end_sweep("bp", d0, 3);
      if (vdly_cyc_q.size() >= 3) begin
         check("bp_vdly_gap1", vdly_cyc_q[1] - vdly_cyc_q[0], 4);
         check("bp_vdly_gap2", vdly_cyc_q[2] - vdly_cyc_q[1], 1);
      end

      // Wrap-around past 2^32.
      vdly_cyc_q.delete();
      d0 = done_count;
      push_beat(32'hFFFF_FFF0, 1'b0);
      push_beat(32'h0000_0010, 1'b0);
      start_sweep(32'hFFFF_FFF0, 32'h0000_0020, 16'd2);
      end_sweep("wrap", d0, 2);

      // Empty sweep.
      vdly_cyc_q.delete();
      d0 = done_count;
      start_sweep(32'h1234_5678, 32'h0000_0001, 16'd0);
      check("empty_done", bus.done, 1);
      check("empty_busy", bus.busy, 0);
      @(posedge clk);
      #1;
      check("empty_done_low", bus.done, 0);
      check("empty_busy_after", bus.busy, 0);
      end_sweep("empty", d0, 0);

      // Reset during the 5th beat of a 360-beat 1-degree sweep.
      vdly_cyc_q.delete();
      d0 = done_count;
      a0 = acc_count;
      for (int i = 0; i < 360; i++) begin
         exp_q.push_back(model_fold(STEP1 * 32'(i)));
      end
      start_sweep(32'h0000_0000, STEP1, 16'd360);
      repeat (4) @(posedge clk);
      #1;
      check("rst_mid_accepted", acc_count - a0, 4);
      check("rst_mid_angle_pre", bus.angle_out, model_fold(STEP1 * 32'd4).angle);
      v0 = vdly_count;
      reset_n = 1'b0;
      #1;
      check("rst_mid_angle_out", bus.angle_out, 0);
      check("rst_mid_angle_valid", bus.angle_valid, 0);
      check("rst_mid_fold_out", bus.fold_out, 0);
      check("rst_mid_valid_dly", bus.valid_dly, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_done", bus.done, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (LAT + 8) @(posedge clk);
      #1;
      check("rst_mid_no_done", done_count - d0, 0);
      check("rst_mid_no_vdly", vdly_count - v0, 0);
      check("rst_mid_idle", bus.busy, 0);

      // A new sweep after the abandoned one.
      vdly_cyc_q.delete();
      d0 = done_count;
      push_beat(32'h2000_0000, 1'b0);
      push_beat(32'hE000_0000, 1'b1);
      push_beat(32'h2000_0000, 1'b1);
      start_sweep(32'h2000_0000, 32'h4000_0000, 16'd3);
      end_sweep("post_rst", d0, 3);

      // Start pulsed while running, with a different count and phase.
      vdly_cyc_q.delete();
      d0 = done_count;
      push_beat(32'h0000_0000, 1'b0);
      push_beat(32'h1000_0000, 1'b0);
      push_beat(32'h2000_0000, 1'b0);
      push_beat(32'h3000_0000, 1'b0);
      push_beat(32'hC000_0000, 1'b1);
      start_sweep(32'h0000_0000, 32'h1000_0000, 16'd5);
      bus.start       = 1'b1;
      bus.count       = 16'd2;
      bus.start_phase = 32'h8000_0000;
      bus.step        = 32'h0000_0001;
      @(posedge clk);
      #1 bus.start = 1'b0;
      end_sweep("busy_start", d0, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_angle_feeder.md
CORDIC_ANGLE_FEEDER -- requirements
Module: cordic_angle_feeder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 16, which is the CORDIC pipeline depth in clock cycles (legal range 1..64).
REQ-002 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: one-cycle request that begins a sweep; honoured only in IDLE.
REQ-005 Port start_phase, input, 32 bits: first phase of the sweep, unsigned binary angle (2^32 = 360 degrees); sampled on start.
REQ-006 Port step, input, 32 bits: phase increment per accepted beat; sampled on start.
REQ-007 Port count, input, 16 bits: number of angles to issue; sampled on start; 0 means an empty sweep.
REQ-008 Port out_ready, input, 1 bit: the downstream CORDIC accepts angle_out this cycle.
REQ-009 Port angle_out, output, 32 bits: signed folded angle in [-90, +90) degrees, same scale as the phase.
REQ-010 Port angle_valid, output, 1 bit: angle_out and fold_out are valid.
REQ-011 Port fold_out, output, 1 bit: 1 means the CORDIC SIN and COS results for this angle must be negated.
REQ-012 Port valid_dly, output, 1 bit: accepted-beat marker, delayed to align with the CORDIC output.
REQ-013 Port fold_dly, output, 1 bit: fold flag, delayed to align with the CORDIC output.
REQ-014 Port busy, output, 1 bit: high in RUN and DRAIN.
REQ-015 Port done, output, 1 bit: one-cycle pulse when a sweep completes.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE with start=1 and count!=0: load phase=start_phase and remaining=count, then go to RUN. angle_valid=1 with the first angle from the next cycle.
REQ-018 IDLE with start=1 and count=0: go directly to DONE, so done pulses exactly one cycle later and no beat is issued.
REQ-019 A beat is accepted on a rising edge where angle_valid=1 and out_ready=1; on acceptance, phase += step modulo 2^32 and remaining decrements.
REQ-020 While out_ready=0, angle_out, fold_out, phase and remaining SHALL hold stable.
REQ-021 Acceptance of the beat with remaining=1: angle_valid=0 from the next cycle, and the FSM goes to DRAIN.
REQ-022 Folding uses q = phase[31:30]. For q=0 or 3: angle_out = phase and fold_out = 0. For q=1 or 2: angle_out = phase with bit 31 inverted (phase minus 180 degrees) and fold_out = 1.
REQ-023 Delay line: a LATENCY-stage shift register of {valid, fold} SHALL advance every cycle, unconditionally. It loads {1, fold_out} on an accepting edge and {0, 0} otherwise.
REQ-024 valid_dly and fold_dly SHALL be high exactly LATENCY cycles after the cycle in which the beat was accepted.
REQ-025 DRAIN goes to DONE on the cycle the delay line holds no valid bit. DONE asserts done for one cycle, then goes to IDLE.
REQ-026 start received in RUN, DRAIN or DONE SHALL be ignored; any start_phase, step or count change outside the start cycle has no effect.

Reset
REQ-027 reset_n=0 SHALL immediately force: FSM=IDLE; phase, remaining, angle_out and all delay-line stages to 0; angle_valid, fold_out, valid_dly, fold_dly, busy and done to 0.
REQ-028 Reset asserted mid-sweep SHALL abandon the sweep; no done pulse follows it.

Structure
REQ-029 A shared package cordic_pkg SHALL hold: ANGLE_W=32, DATA_W=16, the default LATENCY, and the state enum type.
REQ-030 The delay line SHALL be a sub-module cordic_tag_delay, parameterised by depth and tag width.

Verification
REQ-031 Quadrant sweep: start_phase=0, step=0x4000_0000, count=4, out_ready=1. Required angle_out/fold_out pairs: 0x0000_0000/0, 0xC000_0000/1, 0x0000_0000/1, 0xC000_0000/0. done pulses LATENCY+1 cycles after the last accept.
REQ-032 Backpressure: count=3, out_ready=0 for 3 cycles on the second beat. Required: the second angle is held unchanged; exactly 3 valid_dly pulses; the valid_dly pulses reproduce the 3-cycle gap.
REQ-033 Wrap-around: start_phase=0xFFFF_FFF0, step=0x20, count=2. Required angles: 0xFFFF_FFF0/0, then 0x0000_0010/0.
REQ-034 Empty sweep: count=0. Required: busy stays 0, done pulses one cycle after start, angle_valid never asserts.
REQ-035 Reset mid-sweep: reset_n low in RUN during the 5th beat of a 360-beat, 1-degree sweep. Required: all outputs read 0 at once, no done pulse, and a new start works normally.
REQ-036 Start while busy: start=1 in RUN with a different count. Required: the beat count is unaffected and exactly one done pulse is produced.
